// File: rtl/risc_v_pkg.sv
// Shared RV32I encoding constants, class codes and loader types.
// Also consumed by the opcode/funct3 control decoder of the core.
package risc_v_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_I_ALU  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } ld_state_t;

    typedef struct packed {
        logic        valid;
        logic        imm_err;
        logic        illegal;
        logic [31:0] word;
    } ld_s1_t;

    // True when bits [31:msb] are all equal, i.e. v fits a signed (msb+1)-bit field.
    function automatic logic imm_fits(input logic [31:0] v, input int unsigned msb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << msb;
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I packer: instruction class plus fields to a 32-bit word,
// with immediate range/alignment and legality flags.
module instr_field_pack
    import risc_v_pkg::*;
(
    input  logic [3:0]  i_class,
    input  logic [2:0]  i_funct3,
    input  logic        i_f7b5,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_imm_err,
    output logic        o_illegal
);

    logic w_shift;
    logic w_i_ok;

    assign w_shift = (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);
    assign w_i_ok  = imm_fits(i_imm, 11);

    always_comb begin
        o_word    = 32'h0;
        o_imm_err = 1'b0;
        o_illegal = 1'b0;
        case (i_class)
            CLS_R: begin
                o_word = {1'b0, i_f7b5, 5'b0, i_rs2, i_rs1,
                          i_funct3, i_rd, OP_R};
            end
            CLS_I_ALU: begin
                if (w_shift) begin
                    // slli has no arithmetic variant, srli/srai share f3
                    o_illegal = (i_funct3 == F3_SLL) & i_f7b5;
                    o_imm_err = |i_imm[31:5];
                    o_word    = {1'b0, i_f7b5, 5'b0, i_imm[4:0], i_rs1,
                                 i_funct3, i_rd, OP_IMM};
                end else begin
                    o_imm_err = ~w_i_ok;
                    o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM};
                end
            end
            CLS_LOAD: begin
                o_imm_err = ~w_i_ok;
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            end
            CLS_STORE: begin
                o_imm_err = ~w_i_ok;
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                o_imm_err = ~imm_fits(i_imm, 12) | i_imm[0];
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OP_BRANCH};
            end
            CLS_JAL: begin
                o_imm_err = ~imm_fits(i_imm, 20) | i_imm[0];
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                             i_rd, OP_JAL};
            end
            CLS_JALR: begin
                o_imm_err = ~w_i_ok;
                o_word    = {i_imm[11:0], i_rs1, F3_JALR, i_rd, OP_JALR};
            end
            CLS_LUI: begin
                o_imm_err = |i_imm[11:0];
                o_word    = {i_imm[31:12], i_rd, OP_LUI};
            end
            CLS_AUIPC: begin
                o_imm_err = |i_imm[11:0];
                o_word    = {i_imm[31:12], i_rd, OP_AUIPC};
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts field-level instruction requests, encodes them and writes the
// words sequentially into instruction memory through a one-stage pipeline.
module instr_encoder_loader
    import risc_v_pkg::*;
#(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal,
    output logic              err_imm
);

    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_LAST  = {1'b0, {ADDR_W{1'b1}}};

    logic [31:0]     w_word;
    logic            w_imm_err;
    logic            w_illegal;

    ld_state_t       r_state;
    ld_state_t       w_state_nxt;
    ld_s1_t          r_s1;
    logic [ADDR_W:0] r_count;
    logic            r_err_imm;
    logic            r_err_illegal;

    logic            w_full;
    logic            w_wr;
    logic            w_last;
    logic            w_ready;
    logic            w_accept;
    logic [31:0]     w_ptr_byte;

    instr_field_pack u_pack (
        .i_class   (in_class),
        .i_funct3  (in_funct3),
        .i_f7b5    (in_f7b5),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_imm_err (w_imm_err),
        .o_illegal (w_illegal)
    );

    assign w_full     = (r_count == C_DEPTH);
    assign w_wr       = r_s1.valid & ~r_s1.imm_err & ~r_s1.illegal
                      & ~clear & ~w_full;
    assign w_last     = w_wr & (r_count == C_LAST);
    assign w_accept   = in_valid & w_ready;
    assign w_ptr_byte = 32'(r_count[ADDR_W-1:0]) << 2;

    // The word filling the last slot blocks acceptance so nothing overflows.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_ready = ~w_full & ~clear & ~w_last;
                if (w_last) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (clear) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_s1          <= '0;
            r_count       <= '0;
            r_err_imm     <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_s1.valid    <= 1'b0;
                r_count       <= '0;
                r_err_imm     <= 1'b0;
                r_err_illegal <= 1'b0;
            end else begin
                r_s1.valid <= w_accept;
                if (w_accept) begin
                    r_s1.word    <= w_word;
                    r_s1.imm_err <= w_imm_err;
                    r_s1.illegal <= w_illegal;
                end
                if (w_wr) begin
                    r_count <= r_count + 1'b1;
                end
                if (r_s1.valid & r_s1.imm_err) begin
                    r_err_imm <= 1'b1;
                end
                if (r_s1.valid & r_s1.illegal) begin
                    r_err_illegal <= 1'b1;
                end
            end
        end
    end

    assign in_ready    = w_ready;
    assign mem_we      = w_wr;
    assign mem_addr    = w_wr ? (BASE_ADDR + w_ptr_byte) : 32'h0;
    assign mem_wdata   = w_wr ? r_s1.word : 32'h0;
    assign count       = r_count;
    assign full        = w_full;
    assign err_illegal = r_err_illegal;
    assign err_imm     = r_err_imm;

endmodule
